// File: rtl/apb_uart_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_uart_sequencer_if
// Purpose  : Bundles the APB master request/response signals and the two
//            AXI-Stream byte channels used by apb_uart_sequencer.
// Modports : master - the sequencer (drives the APB request, TX tready,
//                     RX tdata/tvalid)
//            slave  - the environment (APB completer, stream source/sink)
// Revision : 1.0 - initial release
// ============================================================================
interface apb_uart_sequencer_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    // APB request / completer response
    logic [APB_ADDR_WIDTH-1:0] paddr_o;
    logic                      psel_o;
    logic                      penable_o;
    logic                      pwrite_o;
    logic [APB_DATA_WIDTH-1:0] pwdata_o;
    logic [APB_DATA_WIDTH-1:0] prdata_i;
    logic                      pready_i;
    logic                      pslverr_i;
    // Bytes to transmit
    logic [7:0]                s_axis_tdata_i;
    logic                      s_axis_tvalid_i;
    logic                      s_axis_tready_o;
    // Received bytes
    logic [7:0]                m_axis_tdata_o;
    logic                      m_axis_tvalid_o;
    logic                      m_axis_tready_i;

    modport master (
        output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
        input  prdata_i, pready_i, pslverr_i,
        input  s_axis_tdata_i, s_axis_tvalid_i,
        output s_axis_tready_o,
        output m_axis_tdata_o, m_axis_tvalid_o,
        input  m_axis_tready_i
    );

    modport slave (
        input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
        output prdata_i, pready_i, pslverr_i,
        output s_axis_tdata_i, s_axis_tvalid_i,
        input  s_axis_tready_o,
        input  m_axis_tdata_o, m_axis_tvalid_o,
        output m_axis_tready_i
    );
endinterface
`default_nettype wire

// File: rtl/apb_uart_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : apb_uart_sequencer
// Purpose  : Autonomous APB master for the UART peripheral. Programs the
//            divider and control registers, then polls status and moves
//            bytes between the AXI-Stream channels and the UART data
//            registers, alternating round-robin when both directions have
//            work.
// Ports    : clk_i, rst_i          - clock, asynchronous active-high reset
//            cfg_start_i           - pulse: reprogram with current cfg inputs
//            clk_divider_i         - divider value (zero-extended on write)
//            parity_odd_i/even_i   - control bits 3 / 2
//            bus (master modport)  - APB request/response + AXI-Stream TX/RX
//            cfg_done_o            - configuration complete
//            parity_err_o          - status bit 4 from the last poll
//            apb_err_o             - sticky pslverr flag
// Revision : 1.0 - initial release
// ============================================================================
module apb_uart_sequencer #(
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter logic [APB_ADDR_WIDTH-1:0] CTRL_ADDR      = 'h0,
    parameter logic [APB_ADDR_WIDTH-1:0] CLKDIV_ADDR    = 'h4,
    parameter logic [APB_ADDR_WIDTH-1:0] TX_ADDR        = 'h8,
    parameter logic [APB_ADDR_WIDTH-1:0] STATUS_ADDR    = 'hC,
    parameter logic [APB_ADDR_WIDTH-1:0] RX_ADDR        = 'h10,
    parameter int                        POLL_GAP       = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_start_i,
    input  logic [15:0]         clk_divider_i,
    input  logic                parity_odd_i,
    input  logic                parity_even_i,
    apb_uart_sequencer_if.master bus,
    output logic                cfg_done_o,
    output logic                parity_err_o,
    output logic                apb_err_o
);

    typedef enum logic [2:0] {
        S_CFG_DIV = 3'd0,
        S_CFG_RST = 3'd1,
        S_CFG_REL = 3'd2,
        S_POLL    = 3'd3,
        S_RD_RX   = 3'd4,
        S_WR_TX   = 3'd5,
        S_GAP     = 3'd6
    } state_t;

    state_t                    r_state;
    logic                      r_psel, r_penable, r_pwrite;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic [7:0]                r_m_tdata;
    logic                      r_m_tvalid;
    logic                      r_prio_tx;   // 1: TX wins the next tie
    logic                      r_pending;   // reconfigure requested
    logic [15:0]               r_gap_cnt;
    logic                      r_cfg_done, r_parity_err, r_apb_err;

    logic                      w_done, w_rx_empty, w_tx_full, w_parity;
    logic                      w_rx_ok, w_tx_ok, w_gap_end, w_start, w_launch;
    logic                      w_take_cfg, w_tx_sel;
    state_t                    w_after, w_next;
    logic [APB_ADDR_WIDTH-1:0] w_ld_addr;
    logic                      w_ld_write;
    logic [APB_DATA_WIDTH-1:0] w_ld_wdata, w_ctrl;
    logic                      w_unused;

    always_comb begin
        w_done     = r_psel & r_penable & bus.pready_i;
        // An errored poll looks like "RX empty, TX not full, no parity error"
        w_rx_empty = bus.pslverr_i | bus.prdata_i[0];
        w_tx_full  = ~bus.pslverr_i & bus.prdata_i[3];
        w_parity   = ~bus.pslverr_i & bus.prdata_i[4];
        w_rx_ok    = ~w_rx_empty & ~r_m_tvalid;
        w_tx_ok    = ~w_tx_full & bus.s_axis_tvalid_i;
        w_gap_end  = (r_state == S_GAP) && (r_gap_cnt == 16'd1);
        // First cycle out of reset: nothing in flight, launch current state
        w_start    = ~r_psel && (r_state != S_GAP);
        w_launch   = w_done | w_gap_end | w_start;

        case (r_state)
            S_CFG_DIV: w_after = S_CFG_RST;
            S_CFG_RST: w_after = S_CFG_REL;
            S_CFG_REL: w_after = S_POLL;
            S_POLL: begin
                if (bus.pslverr_i)          w_after = S_GAP;
                else if (w_rx_ok && w_tx_ok) w_after = r_prio_tx ? S_WR_TX : S_RD_RX;
                else if (w_rx_ok)           w_after = S_RD_RX;
                else if (w_tx_ok)           w_after = S_WR_TX;
                else                        w_after = S_GAP;
            end
            default:   w_after = S_POLL;
        endcase
        if (w_start) w_after = r_state;

        // Reconfiguration only interrupts at a transaction boundary
        w_take_cfg = w_launch && !w_start && r_pending &&
                     ((w_after == S_POLL) || (w_after == S_GAP));

        w_next = w_after;
        if (w_take_cfg)
            w_next = S_CFG_DIV;
        else if ((w_next == S_GAP) && (POLL_GAP == 0))
            w_next = S_POLL;

        w_tx_sel = w_done && (r_state == S_POLL) && (w_next == S_WR_TX);

        w_ctrl     = '0;
        w_ctrl[3]  = parity_odd_i;
        w_ctrl[2]  = parity_even_i;
        w_ld_addr  = STATUS_ADDR;
        w_ld_write = 1'b0;
        w_ld_wdata = r_pwdata;
        case (w_next)
            S_CFG_DIV: begin
                w_ld_addr        = CLKDIV_ADDR;
                w_ld_write       = 1'b1;
                w_ld_wdata       = '0;
                w_ld_wdata[15:0] = clk_divider_i;
            end
            S_CFG_RST: begin
                w_ld_addr       = CTRL_ADDR;
                w_ld_write      = 1'b1;
                w_ld_wdata      = w_ctrl;
                w_ld_wdata[1:0] = 2'b11;
            end
            S_CFG_REL: begin
                w_ld_addr  = CTRL_ADDR;
                w_ld_write = 1'b1;
                w_ld_wdata = w_ctrl;
            end
            S_RD_RX: w_ld_addr = RX_ADDR;
            S_WR_TX: begin
                w_ld_addr       = TX_ADDR;
                w_ld_write      = 1'b1;
                w_ld_wdata      = '0;
                w_ld_wdata[7:0] = bus.s_axis_tdata_i;
            end
            default: w_ld_addr = STATUS_ADDR;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_CFG_DIV;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_m_tdata    <= '0;
            r_m_tvalid   <= 1'b0;
            r_prio_tx    <= 1'b0;
            r_pending    <= 1'b0;
            r_gap_cnt    <= '0;
            r_cfg_done   <= 1'b0;
            r_parity_err <= 1'b0;
            r_apb_err    <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_take_cfg) | cfg_start_i;

            if (w_done && bus.pslverr_i)
                r_apb_err <= 1'b1;

            if (r_m_tvalid && bus.m_axis_tready_i)
                r_m_tvalid <= 1'b0;
            if (w_done && (r_state == S_RD_RX) && !bus.pslverr_i) begin
                r_m_tdata  <= bus.prdata_i[7:0];
                r_m_tvalid <= 1'b1;
            end

            if (w_done && (r_state == S_POLL)) begin
                r_parity_err <= w_parity;
                if (w_next == S_RD_RX) r_prio_tx <= 1'b1;
                if (w_next == S_WR_TX) r_prio_tx <= 1'b0;
            end

            if (w_done && (r_state == S_CFG_REL))
                r_cfg_done <= 1'b1;
            if (w_take_cfg)
                r_cfg_done <= 1'b0;

            if (r_state == S_GAP && !w_gap_end)
                r_gap_cnt <= r_gap_cnt - 16'd1;

            if (r_psel && !r_penable) begin
                r_penable <= 1'b1;
            end else if (w_launch) begin
                r_state <= w_next;
                if (w_next == S_GAP) begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_gap_cnt <= 16'(POLL_GAP);
                end else begin
                    r_psel    <= 1'b1;
                    r_penable <= 1'b0;
                    r_paddr   <= w_ld_addr;
                    r_pwrite  <= w_ld_write;
                    r_pwdata  <= w_ld_wdata;
                end
            end
        end
    end

    assign bus.paddr_o         = r_paddr;
    assign bus.psel_o          = r_psel;
    assign bus.penable_o       = r_penable;
    assign bus.pwrite_o        = r_pwrite;
    assign bus.pwdata_o        = r_pwdata;
    // Combinational so the byte is accepted in the very cycle the poll
    // completes and is registered into pwdata at the following edge.
    assign bus.s_axis_tready_o = w_tx_sel;
    assign bus.m_axis_tdata_o  = r_m_tdata;
    assign bus.m_axis_tvalid_o = r_m_tvalid;
    assign cfg_done_o          = r_cfg_done;
    assign parity_err_o        = r_parity_err;
    assign apb_err_o           = r_apb_err;

    assign w_unused = ^bus.prdata_i[APB_DATA_WIDTH-1:8];

endmodule
`default_nettype wire

// File: doc/apb_uart_sequencer.md
# apb_uart_sequencer

APB master controller that configures and services the APB UART peripheral autonomously. After reset (or on a reconfigure request) it programs the clock divider and control registers, then continuously polls the status register. It moves bytes from an AXI-Stream slave into the TX data register and from the RX data register to an AXI-Stream master. When both directions have work, it arbitrates between them round-robin.

## Interface
- APB_ADDR_WIDTH, 32: APB address width.
- APB_DATA_WIDTH, 32: APB data width (≥ 16).
- CTRL_ADDR / CLKDIV_ADDR / TX_ADDR / STATUS_ADDR / RX_ADDR, 'h0 / 'h4 / 'h8 / 'hC / 'h10: UART register byte addresses.
- POLL_GAP, 4: idle cycles between an empty poll and the next poll (0 allowed).
- clk_i  in  1  system clock; all logic is on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cfg_start_i  in  1  pulse; request a reprogram with the current cfg inputs.
- clk_divider_i  in  16  divider value written to CLKDIV_ADDR (zero-extended).
- parity_odd_i, parity_even_i  in  1 each  control bits 3 and 2.
- paddr_o  out  APB_ADDR_WIDTH; psel_o, penable_o, pwrite_o  out  1; pwdata_o  out  APB_DATA_WIDTH: APB master request.
- prdata_i  in  APB_DATA_WIDTH; pready_i, pslverr_i  in  1: APB completer response.
- s_axis_tdata_i  in  8; s_axis_tvalid_i  in  1; s_axis_tready_o  out  1: bytes to transmit.
- m_axis_tdata_o  out  8; m_axis_tvalid_o  out  1; m_axis_tready_i  in  1: received bytes.
- cfg_done_o  out  1  high once configuration has completed; cleared while reprogramming.
- parity_err_o  out  1  status bit 4 from the last poll.
- apb_err_o  out  1  sticky; set by any pslverr; cleared only by reset.

## Operation
- Control word: bit0 rx_reset, bit1 tx_reset, bit2 parity_even, bit3 parity_odd.
- Status word: bit0 rx_fifo_empty, bit1 tx_fifo_empty, bit2 rx_fifo_full, bit3 tx_fifo_full, bit4 parity_err.
- States: CFG_DIV → CFG_RST → CFG_REL → POLL → (RD_RX | WR_TX | GAP) → POLL.
  - CFG_DIV: write clk_divider_i to CLKDIV_ADDR.
  - CFG_RST: write the parity bits with bits[1:0]=2'b11 to CTRL_ADDR.
  - CFG_REL: write the same word with bits[1:0]=2'b00; then set cfg_done_o.
  - POLL: read STATUS_ADDR; capture parity_err_o.
    - rx_ok = !rx_fifo_empty && !m_axis_tvalid_o.
    - tx_ok = !tx_fifo_full && s_axis_tvalid_i, sampled in the poll's completion cycle.
    - If only one is ok, go to its state. If both are ok, go to the direction not served last (priority bit; RX wins after reset). If neither is ok, go to GAP.
  - RD_RX: read RX_ADDR; load prdata_i[7:0] into the output register and assert m_axis_tvalid_o.
  - WR_TX: write the captured byte to TX_ADDR.
  - GAP: wait POLL_GAP cycles, then POLL.
- TX byte capture: s_axis_tready_o is high for exactly the one cycle of the POLL→WR_TX transition. The byte is registered into pwdata_o at that edge. s_axis_tready_o is otherwise 0.
- The output register holds m_axis_tdata_o/m_axis_tvalid_o until m_axis_tready_i; the valid flag clears on that handshake.
- cfg_start_i is latched in a pending flag.
  - The flag is acted on only at a transaction boundary, i.e. when the next state would be POLL or GAP.
  - Acting on it clears cfg_done_o and enters CFG_DIV.
  - The output register and any captured TX byte are preserved.
- pslverr on any transfer sets apb_err_o and the transfer counts as complete.
  - RD_RX with pslverr: the data is discarded; m_axis_tvalid_o is not set.
  - POLL with pslverr: the status is treated as all-empty/not-full, so the next state is GAP.

## Timing
- APB transfer: SETUP cycle (psel_o=1, penable_o=0), then ACCESS (psel_o=1, penable_o=1) until pready_i=1. paddr/pwrite/pwdata are stable across both phases.
- Transfers are back-to-back: the next SETUP follows the completing ACCESS cycle directly.
- With pready_i tied high, every transfer takes 2 cycles.
  - Reset to cfg_done_o takes 6 cycles; cfg_done_o is high in cycle 7.
  - Best-case turnaround: POLL + RD_RX = 4 cycles per byte; POLL + WR_TX = 4 cycles per byte.
- m_axis_tvalid_o rises on the cycle after the RD_RX ACCESS completes.
- Reset values:
  - psel_o, penable_o, pwrite_o = 0; paddr_o, pwdata_o = 0.
  - s_axis_tready_o = 0; m_axis_tvalid_o = 0; m_axis_tdata_o = 0.
  - cfg_done_o, parity_err_o, apb_err_o = 0; RR priority = RX.
  - State leaves reset into CFG_DIV.
- Asserting rst_i mid-transfer drops psel_o/penable_o immediately (asynchronous); the transfer is abandoned.
- A cfg_start_i pulse arriving during configuration re-runs the whole configuration once after the current one completes.

## Test plan
- Reset, pready=1, clk_divider_i=16'd868, parity_even_i=1 → APB writes 'h4←868, 'h0←'h7, 'h0←'h4 in cycles 1-6; cfg_done_o=1 in cycle 7.
- Status reads 'h1 (rx empty), s_axis sends 'hA5 → single tready pulse; write 'h8←'hA5; next transfer is a POLL.
- Status reads 'h2 (rx not empty), RX reads 'h3C, m_axis_tready_i=0 → m_axis holds 'h3C; subsequent polls go to GAP (POLL_GAP cycles) and issue no RX read until m_axis_tready_i=1.
- Both rx_ok and tx_ok on every poll → the data-transfer sequence alternates RX, TX, RX, TX, starting with RX.
- pready_i held low for 5 cycles during a TX write, then pslverr=1 → ACCESS is held 6 cycles; apb_err_o=1 and stays set; sequencer returns to POLL.
- cfg_start_i pulse mid-RD_RX → the read completes and its byte is delivered; then CFG_DIV/CFG_RST/CFG_REL run; cfg_done_o is low during the reprogram and high after.
